cellrv32_cpu_cp_ctrl: RTL
=========================

Name: cellrv32_cpu_cp_ctrl

Overview:
Co-processor dispatch and result-collection stage that sits directly upstream and downstream of the ALU co-processors (shifter, multiplier/divider, bit-manipulation, ...).
- Accepts a one-hot operation request from the ALU and pulses the selected co-processor's start.
- Tracks the operation until that co-processor reports valid, then captures its result one cycle later.
- Returns the result to the ALU with a single-cycle done strobe.
- Handles trap aborts and co-processor timeouts.

Parameters:
NUM_CP, 4, number of attached co-processors (1..8)
XLEN, 32, data path width
TMO_CYCLES, 64, max cycles in BUSY before timeout (power of 2, >= 4)

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, asynchronous, active-low
trap_i  in  1  CPU trap, aborts any running operation
sel_i  in  NUM_CP  one-hot request; bit n triggers co-processor n
cp_start_o  out  NUM_CP  one-cycle start pulse per co-processor
cp_valid_i  in  NUM_CP  co-processor valid (result appears on cp_res_i the following cycle)
cp_res_i  in  NUM_CP*XLEN  co-processor results, flat; slice n = bits [n*XLEN +: XLEN]; zero when a co-processor is idle
res_o  out  XLEN  operation result, non-zero only while done_o=1
done_o  out  1  result valid strobe (one cycle)
busy_o  out  1  operation in flight (state != IDLE)
exc_o  out  1  one-cycle error strobe (timeout or illegal multi-hot request)

Behaviour:
- Clock and reset: one clock, clk_i; reset rstn_i is asynchronous, active-low.
- Reset values: state=IDLE, active mask=0, timeout counter=0, result register=0. Outputs: res_o=0, done_o=0, busy_o=0, exc_o=0, cp_start_o=0.
- States: IDLE, BUSY, CAPTURE, DONE.
- IDLE:
  - cp_start_o = sel_i when sel_i is exactly one-hot and trap_i=0; otherwise 0. This output is combinational.
  - A legal request stores the active mask = sel_i.
  - If (cp_valid_i & sel_i) != 0 in the same cycle (barrel-style co-processor), go to CAPTURE. Otherwise go to BUSY, with counter=0.
  - sel_i with two or more bits set: no start, exc_o=1 next cycle, stay IDLE.
  - sel_i=0: stay IDLE.
- BUSY:
  - Counter increments each cycle.
  - (cp_valid_i & active) != 0: go to CAPTURE.
  - Counter == TMO_CYCLES-1 with no valid: exc_o=1 for one cycle, go to IDLE, no done. The timeout is measured from entry into BUSY.
  - cp_valid_i bits not in the active mask are ignored.
- CAPTURE:
  - Result register <= OR over n of (cp_res_i slice n AND replicate(active[n])).
  - Go to DONE.
- DONE:
  - done_o=1 and res_o=result register, for exactly one cycle.
  - Then go to IDLE and clear the active mask.
  - No new request is accepted in DONE. sel_i is ignored in every non-IDLE state.
- Outputs:
  - res_o is 0 in every state except DONE.
  - done_o and exc_o are never asserted together.
- Latency, start to done_o:
  - 2 cycles when valid is in the start cycle.
  - k+2 cycles when valid arrives k cycles after start.
- Trap handling:
  - trap_i=1 in BUSY or CAPTURE: go to IDLE next cycle. No done, no exc, result register unchanged.
  - trap_i=1 in DONE: done still completes (result already committed).
  - trap_i=1 in IDLE: suppresses cp_start_o and the request.
- Simultaneous events:
  - Valid and timeout in the same BUSY cycle: valid wins (go to CAPTURE, no exc).
  - Trap and valid in the same cycle: trap wins.
- busy_o is a registered decode (state != IDLE). It is 1 from the cycle after an accepted start until the cycle after DONE/abort.

Test Plan:
1. Barrel-style: sel_i=0001, cp_valid_i[0]=1 in the same cycle, cp_res_i[0] next cycle = 0x0000_0F00 -> cp_start_o=0001 for 1 cycle; done_o=1 with res_o=0x0000_0F00 at cycle+2; res_o=0 otherwise.
2. Serial-style: sel_i=0010, valid[1] at cycle 5, res 0xFFFF_FFF0 at cycle 6 -> done_o at cycle 7, res_o=0xFFFF_FFF0; busy_o=1 cycles 1..7, 0 at 8.
3. Foreign valid: active=0010, cp_valid_i=0100 with cp_res_i[2]=0xDEAD_BEEF, then valid[1] with res 0x1 -> res_o=0x0000_0001 (slice 2 masked out).
4. Timeout: sel_i=1000, no valid ever -> exc_o=1 exactly once at BUSY cycle 63 (TMO_CYCLES=64), no done_o, back to IDLE; next request is accepted.
5. Trap abort: start co-processor 0, trap_i=1 in BUSY cycle 3 -> IDLE next cycle, done_o and exc_o stay 0; later valid[0] is ignored.
6. Illegal multi-hot: sel_i=0011 -> cp_start_o=0000, exc_o=1 one cycle later, busy_o stays 0; async reset mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/cellrv32_cpu_cp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cellrv32_cpu_cp_ctrl
// Purpose  : Co-processor dispatch / result-collection stage. Accepts a
//            one-hot request from the ALU, pulses the matching co-processor
//            start, waits for that co-processor's valid, captures its result
//            one cycle later and hands it back with a one-cycle done strobe.
//            Trap aborts and co-processor timeouts are handled here.
// Ports    : clk_i      - clock, rising edge
//            rstn_i     - asynchronous active-low reset
//            trap_i     - CPU trap, aborts a running operation
//            sel_i      - one-hot co-processor request (NUM_CP)
//            cp_start_o - one-cycle start pulse per co-processor (NUM_CP)
//            cp_valid_i - co-processor valid, result follows next cycle
//            cp_res_i   - flat co-processor results, slice n = [n*XLEN +: XLEN]
//            res_o      - result, non-zero only while done_o=1
//            done_o     - one-cycle result strobe
//            busy_o     - operation in flight
//            exc_o      - one-cycle error strobe (timeout / multi-hot request)
// Revision : 1.0 - initial release
// ============================================================================
module cellrv32_cpu_cp_ctrl #(
   parameter int NUM_CP     = 4,
   parameter int XLEN       = 32,
   parameter int TMO_CYCLES = 64
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   trap_i,
   input  logic [NUM_CP-1:0]      sel_i,
   output logic [NUM_CP-1:0]      cp_start_o,
   input  logic [NUM_CP-1:0]      cp_valid_i,
   input  logic [NUM_CP*XLEN-1:0] cp_res_i,
   output logic [XLEN-1:0]        res_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic                   exc_o
);

   localparam int C_CNT_W = $clog2(TMO_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t              r_state;
   logic [NUM_CP-1:0]   r_active;
   logic [C_CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]     r_res;
   logic                r_exc;

   logic                w_onehot;
   logic                w_multihot;
   logic                w_accept;
   logic                w_hit;
   logic [XLEN-1:0]     w_mux;

   // x & (x-1) clears the lowest set bit; zero afterwards means one bit set
   assign w_onehot   = (sel_i != '0) && ((sel_i & (sel_i - NUM_CP'(1))) == '0);
   assign w_multihot = (sel_i != '0) && !w_onehot;
   assign w_accept   = (r_state == S_IDLE) && w_onehot && !trap_i;
   assign w_hit      = |(cp_valid_i & r_active);

   assign cp_start_o = w_accept ? sel_i : '0;

   // AND-OR result select: idle co-processors drive zero, and any foreign
   // slice is masked off by the active mask anyway
   always_comb begin
      w_mux = '0;
      for (int n = 0; n < NUM_CP; n++) begin
         w_mux = w_mux | (cp_res_i[n*XLEN +: XLEN] & {XLEN{r_active[n]}});
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= S_IDLE;
         r_active <= '0;
         r_cnt    <= '0;
         r_res    <= '0;
         r_exc    <= 1'b0;
      end else begin
         r_exc <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
                  r_active <= sel_i;
                  // barrel-style unit answers in the start cycle
                  if (|(cp_valid_i & sel_i)) begin
                     r_state <= S_CAPTURE;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end else if (w_multihot && !trap_i) begin
                  r_exc <= 1'b1;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + C_CNT_W'(1);
               // priority: trap > valid > timeout
               if (trap_i) begin
                  r_state  <= S_IDLE;
                  r_active <= '0;
               end else if (w_hit) begin
                  r_state <= S_CAPTURE;
               end else if (r_cnt == C_CNT_W'(TMO_CYCLES - 1)) begin
                  r_state  <= S_IDLE;
                  r_active <= '0;
                  r_exc    <= 1'b1;
               end
            end
            S_CAPTURE: begin
               // abort leaves the previous result untouched
               if (trap_i) begin
                  r_state  <= S_IDLE;
                  r_active <= '0;
               end else begin
                  r_res   <= w_mux;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // result already committed, a trap here does not cancel it
               r_state  <= S_IDLE;
               r_active <= '0;
            end
            default: begin
               r_state  <= S_IDLE;
               r_active <= '0;
            end
         endcase
      end
   end

   assign done_o = (r_state == S_DONE);
   assign res_o  = (r_state == S_DONE) ? r_res : '0;
   assign busy_o = (r_state != S_IDLE);
   assign exc_o  = r_exc;

endmodule
`default_nettype wire
